// File: rtl/lighthouse_pkg.sv
// Shared definitions for the lighthouse transmit/receive chain: LFSR width,
// burst FSM encoding and the default BMC half-cell length.
package lighthouse_pkg;

    localparam int unsigned LFSR_W                  = 17;
    localparam int unsigned DEFAULT_HALF_BIT_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SEND,
        TRAIL
    } lh_state_e;

endpackage

// File: rtl/lfsr17_step.sv
// One step of the 17-bit Fibonacci LFSR: MSB is the bit currently on air,
// next state shifts left with the parity of the tapped bits as new LSB.
module lfsr17_step
    import lighthouse_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] polynomial,
    output logic [LFSR_W-1:0] next_state,
    output logic              out_bit
);

    always_comb begin
        out_bit    = state[LFSR_W-1];
        next_state = {state[LFSR_W-2:0], ^(state & polynomial)};
    end

endmodule

// File: rtl/bmc_lighthouse_emitter.sv
// Biphase-mark-coded LFSR burst generator driving an envelop/data pair the
// way a TS4231 front end presents a base-station sweep to the receiver.
module bmc_lighthouse_emitter
    import lighthouse_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = DEFAULT_HALF_BIT_CYCLES,
    parameter int unsigned LEAD_CYCLES     = 16,
    parameter int unsigned TRAIL_CYCLES    = 16,
    parameter logic        ENVELOP_ACTIVE  = 1'b0,
    parameter int unsigned COUNT_W         = 12
) (
    input  logic               clk_96MHz,
    input  logic               reset,
    input  logic               start,
    input  logic [LFSR_W-1:0]  polynomial,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [COUNT_W-1:0] bit_count,
    output logic               envelop,
    output logic               data,
    output logic               busy,
    output logic               done,
    output logic [LFSR_W-1:0]  lfsr_state
);

    localparam int unsigned CELL_CYCLES = 2 * HALF_BIT_CYCLES;
    localparam int unsigned HC_W        = $clog2(CELL_CYCLES);
    localparam int unsigned PH_MAX      = (LEAD_CYCLES > TRAIL_CYCLES) ? LEAD_CYCLES : TRAIL_CYCLES;
    localparam int unsigned PH_W        = $clog2(PH_MAX + 1);

    lh_state_e          state;
    lh_state_e          state_nxt;
    logic [PH_W-1:0]    phase;
    logic [HC_W-1:0]    half_cnt;
    logic [COUNT_W-1:0] bits_left;
    logic [LFSR_W-1:0]  poly_q;
    logic [LFSR_W-1:0]  lfsr_next;
    logic               cur_bit;
    logic               data_q;
    logic               done_q;

    logic accept;
    logic lead_last;
    logic trail_last;
    logic mid_cell;
    logic cell_last;
    logic last_bit;

    assign accept     = start && (bit_count != '0);
    assign lead_last  = (phase == PH_W'(LEAD_CYCLES - 1));
    assign trail_last = (phase == PH_W'(TRAIL_CYCLES - 1));
    assign mid_cell   = (half_cnt == HC_W'(HALF_BIT_CYCLES - 1));
    assign cell_last  = (half_cnt == HC_W'(CELL_CYCLES - 1));
    assign last_bit   = (bits_left == COUNT_W'(1));

    lfsr17_step u_step (
        .state      (lfsr_state),
        .polynomial (poly_q),
        .next_state (lfsr_next),
        .out_bit    (cur_bit)
    );

    always_ff @(posedge clk_96MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                state_nxt = LEAD;
            LEAD:    if (lead_last)             state_nxt = SEND;
            SEND:    if (cell_last && last_bit) state_nxt = TRAIL;
            TRAIL:   if (trail_last)            state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Data edges are registered on the edge that enters a cell (always) and
    // the edge that enters its second half (only for a 1 bit).
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            phase      <= '0;
            half_cnt   <= '0;
            bits_left  <= '0;
            poly_q     <= '0;
            lfsr_state <= '0;
            data_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    phase    <= '0;
                    half_cnt <= '0;
                    data_q   <= 1'b0;
                    if (accept) begin
                        poly_q     <= polynomial;
                        lfsr_state <= seed;
                        bits_left  <= bit_count;
                    end
                end
                LEAD: begin
                    if (lead_last) begin
                        phase    <= '0;
                        half_cnt <= '0;
                        data_q   <= ~data_q;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                SEND: begin
                    if (cell_last) begin
                        half_cnt   <= '0;
                        lfsr_state <= lfsr_next;
                        bits_left  <= bits_left - 1'b1;
                        if (!last_bit) data_q <= ~data_q;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                        if (mid_cell && cur_bit) data_q <= ~data_q;
                    end
                end
                TRAIL: begin
                    if (trail_last) begin
                        phase  <= '0;
                        data_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    phase    <= '0;
                    half_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        envelop = (state == IDLE) ? ~ENVELOP_ACTIVE : ENVELOP_ACTIVE;
        busy    = (state != IDLE);
        data    = data_q;
        done    = done_q;
    end

endmodule

// File: tb/tb_bmc_lighthouse_emitter.sv
// Directed bench for bmc_lighthouse_emitter with default parameters; expected
// waveforms come from hand-derived constants and an independent BMC/LFSR model.
module tb_bmc_lighthouse_emitter;

    logic        clk_96MHz = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] polynomial;
    logic [16:0] seed;
    logic [11:0] bit_count;
    logic        envelop;
    logic        data;
    logic        busy;
    logic        done;
    logic [16:0] lfsr_state;

    int checks = 0;
    int errors = 0;

    logic env_r  [0:1023];
    logic dat_r  [0:1023];
    logic busy_r [0:1023];
    logic done_r [0:1023];
    logic exp_d  [0:1023];

    logic [16:0] fin;

    always #5 clk_96MHz = ~clk_96MHz;

    bmc_lighthouse_emitter #(
        .HALF_BIT_CYCLES (8),
        .LEAD_CYCLES     (16),
        .TRAIL_CYCLES    (16),
        .ENVELOP_ACTIVE  (1'b0),
        .COUNT_W         (12)
    ) dut (
        .clk_96MHz  (clk_96MHz),
        .reset      (reset),
        .start      (start),
        .polynomial (polynomial),
        .seed       (seed),
        .bit_count  (bit_count),
        .envelop    (envelop),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .lfsr_state (lfsr_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_96MHz);
        #1;
    endtask

    task automatic sample(input int k);
        env_r[k]  = envelop;
        dat_r[k]  = data;
        busy_r[k] = busy;
        done_r[k] = done;
    endtask

    // Sample index 0 is taken just after the edge that accepts start.
    task automatic do_start(input logic [16:0] p, input logic [16:0] s, input logic [11:0] c);
        polynomial = p;
        seed       = s;
        bit_count  = c;
        start      = 1'b1;
        tick();
        start = 1'b0;
        sample(0);
    endtask

    task automatic run(input int n, input int start_at, input int reset_at,
                       input logic [16:0] ip, input logic [16:0] is, input logic [11:0] ic);
        for (int k = 1; k <= n; k++) begin
            if (k == start_at) begin
                polynomial = ip;
                seed       = is;
                bit_count  = ic;
                start      = 1'b1;
            end
            if (k == reset_at) reset = 1'b1;
            tick();
            start = 1'b0;
            reset = 1'b0;
            sample(k);
        end
    endtask

    function automatic int count_active(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (env_r[k] === 1'b0) n++;
        return n;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (done_r[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (busy_r[k] === 1'b1) n++;
        return n;
    endfunction

    // Expected data level after each edge relative to the accepting edge.
    function automatic logic [16:0] model(input logic [16:0] s, input logic [16:0] p,
                                          input int c, input int base);
        logic        lvl  = 1'b0;
        logic [16:0] st   = s;
        int          endk = 32 + 16 * c;
        int          pos;
        for (int k = 0; k <= endk; k++) begin
            if (k >= 16 && k < 16 + 16 * c) begin
                pos = (k - 16) % 16;
                if (pos == 0) lvl = ~lvl;
                if (pos == 8 && st[16]) lvl = ~lvl;
                if (pos == 15) st = {st[15:0], ^(st & p)};
            end
            if (k == endk) lvl = 1'b0;
            exp_d[base + k] = lvl;
        end
        return st;
    endfunction

    task automatic cmp_wave(input string tag, input int base, input int endk);
        int m = 0;
        for (int k = 0; k <= endk; k++) if (dat_r[base + k] !== exp_d[base + k]) m++;
        check({tag, "_wave"}, 32'(m), 32'd0);
        check({tag, "_done_at"}, 32'(done_r[base + endk]), 32'd1);
        check({tag, "_env_len"}, 32'(count_active(base, base + endk)), 32'(endk));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        polynomial = '0;
        seed       = '0;
        bit_count  = '0;
        tick();
        tick();
        check("rst_env",  32'(envelop),    32'd1);
        check("rst_data", 32'(data),       32'd0);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_done", 32'(done),       32'd0);
        check("rst_lfsr", 32'(lfsr_state), 32'd0);
        reset = 1'b0;
        tick();

        // Single burst: bits 1,0,0
        do_start(17'h00001, 17'h10000, 12'd3);
        check("t1_env0",  32'(env_r[0]),   32'd0);
        check("t1_busy0", 32'(busy_r[0]),  32'd1);
        check("t1_seed",  32'(lfsr_state), 32'h10000);
        run(90, 0, 0, '0, '0, '0);
        check("t1_d15", 32'(dat_r[15]), 32'd0);
        check("t1_d16", 32'(dat_r[16]), 32'd1);
        check("t1_d23", 32'(dat_r[23]), 32'd1);
        check("t1_d24", 32'(dat_r[24]), 32'd0);
        check("t1_d31", 32'(dat_r[31]), 32'd0);
        check("t1_d32", 32'(dat_r[32]), 32'd1);
        check("t1_d47", 32'(dat_r[47]), 32'd1);
        check("t1_d48", 32'(dat_r[48]), 32'd0);
        check("t1_d79", 32'(dat_r[79]), 32'd0);
        check("t1_env79",  32'(env_r[79]),  32'd0);
        check("t1_env80",  32'(env_r[80]),  32'd1);
        check("t1_done79", 32'(done_r[79]), 32'd0);
        check("t1_done80", 32'(done_r[80]), 32'd1);
        check("t1_done81", 32'(done_r[81]), 32'd0);
        check("t1_busy80", 32'(busy_r[80]), 32'd0);
        check("t1_dcount", 32'(count_done(0, 90)),   32'd1);
        check("t1_active", 32'(count_active(0, 90)), 32'd80);
        check("t1_lfsr",   32'(lfsr_state), 32'h00000);
        fin = model(17'h10000, 17'h00001, 3, 0);
        cmp_wave("t1", 0, 80);

        // Start while busy is ignored, including its new inputs
        do_start(17'h00001, 17'h10000, 12'd3);
        run(90, 20, 0, 17'h1FFFF, 17'h1FFFF, 12'd5);
        check("busy_dcount", 32'(count_done(0, 90)),   32'd1);
        check("busy_active", 32'(count_active(0, 90)), 32'd80);
        check("busy_lfsr",   32'(lfsr_state), 32'h00000);
        fin = model(17'h10000, 17'h00001, 3, 0);
        cmp_wave("busy", 0, 80);

        // bit_count = 0 is ignored
        do_start(17'h1D258, 17'h0ABCD, 12'd0);
        run(20, 0, 0, '0, '0, '0);
        check("zero_active", 32'(count_active(0, 20)), 32'd0);
        check("zero_busy",   32'(count_busy(0, 20)),   32'd0);
        check("zero_done",   32'(count_done(0, 20)),   32'd0);
        check("zero_lfsr",   32'(lfsr_state),          32'h00000);

        // Reset mid-SEND, then a full burst with a real polynomial
        do_start(17'h00001, 17'h10000, 12'd3);
        run(60, 0, 30, '0, '0, '0);
        check("mrst_env29",  32'(env_r[29]),  32'd0);
        check("mrst_env30",  32'(env_r[30]),  32'd1);
        check("mrst_data30", 32'(dat_r[30]),  32'd0);
        check("mrst_busy30", 32'(busy_r[30]), 32'd0);
        check("mrst_data32", 32'(dat_r[32]),  32'd0);
        check("mrst_done",   32'(count_done(0, 60)), 32'd0);
        check("mrst_lfsr",   32'(lfsr_state), 32'h00000);
        do_start(17'h1D258, 17'h0ABCD, 12'd17);
        run(320, 0, 0, '0, '0, '0);
        fin = model(17'h0ABCD, 17'h1D258, 17, 0);
        cmp_wave("real", 0, 304);
        check("real_dcount", 32'(count_done(0, 320)), 32'd1);
        check("real_lfsr",   32'(lfsr_state), 32'(fin));

        // Zero polynomial shifts to zero and still terminates
        do_start(17'h00000, 17'h1FFFF, 12'd20);
        run(370, 0, 0, '0, '0, '0);
        fin = model(17'h1FFFF, 17'h00000, 20, 0);
        cmp_wave("poly0", 0, 352);
        check("poly0_lfsr", 32'(lfsr_state), 32'(fin));

        // Back-to-back: start in the done cycle
        do_start(17'h00001, 17'h10000, 12'd3);
        run(170, 81, 0, 17'h1D258, 17'h0ABCD, 12'd3);
        check("b2b_env80",  32'(env_r[80]), 32'd1);
        check("b2b_env81",  32'(env_r[81]), 32'd0);
        check("b2b_dcount", 32'(count_done(0, 170)),   32'd2);
        check("b2b_active", 32'(count_active(0, 170)), 32'd160);
        fin = model(17'h10000, 17'h00001, 3, 0);
        cmp_wave("b2b1", 0, 80);
        fin = model(17'h0ABCD, 17'h1D258, 3, 81);
        cmp_wave("b2b2", 81, 80);
        check("b2b_lfsr", 32'(lfsr_state), 32'(fin));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
